// File: rtl/instr_encoder.sv
// H2BP instruction encoder: packs field bundles into 32-bit instruction words
// and streams them into instruction memory through a held write port.

package h2bp;
  // Memory opcodes occupy the contiguous block LW..SB of word[31:27].
  localparam logic [4:0] LW = 5'b10000;
  localparam logic [4:0] SB = 5'b10111;

  typedef enum logic [2:0] {
    KIND_ALU3     = 3'd0,
    KIND_ALU2_OFS = 3'd1,
    KIND_ALU2_IMM = 3'd2,
    KIND_MEM      = 3'd3,
    KIND_BRANCH   = 3'd4
  } kind_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ILLEGAL  = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_e;
endpackage

module instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 1024,
  parameter logic [1:0]  BR_PREFIX = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);
  import h2bp::*;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   MAXW = (ADDR_W+1)'(MAX_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   acc_q, acc_d;
  logic              err_q, err_d;
  err_e              code_q, code_d;

  logic [31:0] enc_word;
  err_e        enc_code;
  logic        imm12_ok;
  logic        imm16_ok;
  logic        full_c;
  logic        ready_c;
  logic        accept;
  logic        write_done;
  logic        overflow;

  assign imm12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign imm16_ok = (&in_imm[31:15]) | ~(|in_imm[31:15]);

  assign full_c     = (acc_q >= MAXW);
  assign write_done = we_q && mem_ready;
  // start/finish win over a same-cycle bundle, so ready is withheld rather than
  // letting a handshake complete that the session control then discards.
  assign ready_c    = (state_q == S_RUN) && !full_c && (!we_q || mem_ready) && !start && !finish;
  assign accept     = in_valid && ready_c;
  assign overflow   = (state_q == S_RUN) && full_c && in_valid && !start && !finish;

  // Pack fields into an instruction word and classify legality/range.
  always_comb begin
    enc_word = '0;
    enc_code = ERR_NONE;
    case (in_kind)
      KIND_ALU3: begin
        enc_word = {1'b0, in_op[2:0], 1'b0, in_rd, in_rs1, in_rs2, in_imm[11:0]};
        if (!imm12_ok) enc_code = ERR_RANGE;
      end
      KIND_ALU2_OFS, KIND_ALU2_IMM: begin
        enc_word = {1'b0, in_op[2:0], 1'b1, in_rd, in_rs1, in_imm[15:0],
                    (in_kind == KIND_ALU2_IMM)};
        if (!imm16_ok) enc_code = ERR_RANGE;
      end
      KIND_MEM: begin
        enc_word = {in_op, in_rd, in_rs1, 17'b0};
        if (!(in_op inside {[LW:SB]})) enc_code = ERR_ILLEGAL;
      end
      KIND_BRANCH: begin
        enc_word = {BR_PREFIX, in_op[2:0], in_rd, in_rs1, in_imm[15:0], 1'b0};
        if ((in_op[2:0] == 3'b111) || ({BR_PREFIX, in_op[2:0]} inside {[LW:SB]}))
          enc_code = ERR_ILLEGAL;
        else if (!imm16_ok)
          enc_code = ERR_RANGE;
      end
      default: enc_code = ERR_ILLEGAL;
    endcase
  end

  // Session FSM, write port bookkeeping and sticky error capture.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    acc_d   = acc_q;
    err_d   = err_q;
    code_d  = code_q;

    if (write_done) begin
      we_d    = 1'b0;
      addr_d  = addr_q + 1'b1;
      count_d = count_q + 1'b1;
    end

    if (accept) begin
      if (enc_code == ERR_NONE) begin
        we_d    = 1'b1;
        wdata_d = enc_word;
        acc_d   = acc_q + 1'b1;
      end else begin
        err_d = 1'b1;
        if (!err_q) code_d = enc_code;
      end
    end

    if (overflow) begin
      err_d = 1'b1;
      if (!err_q) code_d = ERR_OVERFLOW;
    end

    case (state_q)
      S_RUN:   if (finish) state_d = S_DRAIN;
      S_DRAIN: if (!we_q)  state_d = S_DONE;
      default: state_d = state_q;
    endcase

    // A restart from any state drops the pending write and clears the session.
    if (start) begin
      state_d = S_RUN;
      we_d    = 1'b0;
      addr_d  = BASE;
      count_d = '0;
      acc_d   = '0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= '0;
      count_q <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign in_ready  = ready_c;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign full      = full_c;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule
